// File: rtl/spart_pkg.sv
// Shared SPART definitions: receive/transmit FSM state encoding and framing constants.
package spart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int LAST_TICK  = 15;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; presets to the idle (high) level.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops take non-blocking assignments so meta->q forms a real two-stage pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receive.sv
// SPART receive half: 16x-oversampled 8N1 deframer with a one-entry holding register
// and sticky framing/overrun flags cleared by a bus read.
module uart_receive
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = spart_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = spart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_en,
    input  logic                 i_rx,
    input  logic                 i_iocs,
    input  logic                 i_iorw,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rda,
    output logic                 o_ferr,
    output logic                 o_ovr
);

    localparam logic [3:0] MID_TICK = 4'(MID_SAMPLE);
    localparam logic [3:0] END_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic [3:0]           tcnt, tcnt_nxt;
    logic [2:0]           bcnt, bcnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 rda_nxt, ferr_nxt, ovr_nxt;
    logic                 rx_s;
    logic                 rd;

    rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_rx),
        .q   (rx_s)
    );

    assign rd = i_iocs && !i_iorw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tcnt   <= '0;
            bcnt   <= '0;
            shreg  <= '0;
            o_data <= '0;
            o_rda  <= 1'b0;
            o_ferr <= 1'b0;
            o_ovr  <= 1'b0;
        end else begin
            state  <= state_nxt;
            tcnt   <= tcnt_nxt;
            bcnt   <= bcnt_nxt;
            shreg  <= shreg_nxt;
            o_data <= data_nxt;
            o_rda  <= rda_nxt;
            o_ferr <= ferr_nxt;
            o_ovr  <= ovr_nxt;
        end
    end

    // NOTE: every next-state value gets a hold default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        data_nxt  = o_data;
        rda_nxt   = o_rda;
        ferr_nxt  = o_ferr;
        ovr_nxt   = o_ovr;

        // A read clears the flags; a completing frame below can override that.
        if (rd) begin
            rda_nxt  = 1'b0;
            ferr_nxt = 1'b0;
            ovr_nxt  = 1'b0;
        end

        if (b_en) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        tcnt_nxt  = '0;
                    end
                end
                START: begin
                    if (tcnt == MID_TICK) begin
                        tcnt_nxt  = '0;
                        bcnt_nxt  = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end else begin
                        tcnt_nxt = tcnt + 4'd1;
                    end
                end
                DATA: begin
                    if (tcnt == END_TICK) begin
                        shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                        tcnt_nxt  = '0;
                        if (bcnt == LAST_BIT) state_nxt = STOP;
                        else                  bcnt_nxt  = bcnt + 3'd1;
                    end else begin
                        tcnt_nxt = tcnt + 4'd1;
                    end
                end
                STOP: begin
                    if (tcnt == END_TICK) begin
                        // Leaving at mid stop bit lets a back-to-back start edge be caught.
                        state_nxt = IDLE;
                        tcnt_nxt  = '0;
                        if (rx_s) begin
                            data_nxt = shreg;
                            rda_nxt  = 1'b1;
                            if (o_rda && !rd) ovr_nxt = 1'b1;
                        end else begin
                            ferr_nxt = 1'b1;
                        end
                    end else begin
                        tcnt_nxt = tcnt + 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: b_en every 4 clk, frames driven bit-by-bit at 64 clk per bit.
module tb_uart_receive;

    logic       clk = 1'b0;
    logic       rst;
    logic       b_en;
    logic       i_rx;
    logic       i_iocs;
    logic       i_iorw;
    logic [7:0] o_data;
    logic       o_rda;
    logic       o_ferr;
    logic       o_ovr;

    int errors = 0;
    int checks = 0;
    int div    = 0;
    int rise_at;

    uart_receive dut (
        .clk    (clk),
        .rst    (rst),
        .b_en   (b_en),
        .i_rx   (i_rx),
        .i_iocs (i_iocs),
        .i_iorw (i_iorw),
        .o_data (o_data),
        .o_rda  (o_rda),
        .o_ferr (o_ferr),
        .o_ovr  (o_ovr)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge; b_en is set there for the following rising edge.
    task automatic step();
        @(negedge clk);
        div  = (div + 1) % 4;
        b_en = (div == 0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) step();
    endtask

    task automatic bus_access(input logic rw);
        i_iocs = 1'b1;
        i_iorw = rw;
        step();
        i_iocs = 1'b0;
        i_iorw = 1'b0;
    endtask

    // Drives one 10-bit frame starting on a phase where the first tick after the
    // synchronizer delay lands 3 clk after the start edge; rd_at >= 0 pulses a read
    // so that it is seen on the rising edge at step rd_at+1.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_at);
        logic [9:0] bits;
        logic       rda_prev;
        bits    = {stop, d, 1'b0};
        rise_at = -1;
        while (div != 2) step();
        i_rx     = bits[0];
        rda_prev = o_rda;
        for (int k = 1; k <= 640; k++) begin
            step();
            if (!rda_prev && o_rda && rise_at < 0) rise_at = k;
            rda_prev = o_rda;
            i_rx     = (k < 640) ? bits[k / 64] : 1'b1;
            i_iocs   = (k == rd_at);
            i_iorw   = 1'b0;
        end
    endtask

    initial begin
        rst    = 1'b1;
        b_en   = 1'b0;
        i_rx   = 1'b1;
        i_iocs = 1'b0;
        i_iorw = 1'b0;
        repeat (3) step();
        check("reset_data", o_data, 8'h00);
        check("reset_rda",  o_rda,  1'b0);
        check("reset_ferr", o_ferr, 1'b0);
        check("reset_ovr",  o_ovr,  1'b0);
        rst = 1'b0;
        idle(70);

        // Single frame: rda must rise 152 ticks (608 clk) after the 3-clk sync delay.
        send_frame(8'hA5, 1'b1, -1);
        check("a5_latency", rise_at, 611);
        check("a5_data",    o_data,  8'hA5);
        check("a5_rda",     o_rda,   1'b1);
        check("a5_ferr",    o_ferr,  1'b0);
        check("a5_ovr",     o_ovr,   1'b0);
        bus_access(1'b1);
        check("write_no_effect", o_rda, 1'b1);
        bus_access(1'b0);
        check("read_clears_rda", o_rda,  1'b0);
        check("read_keeps_data", o_data, 8'hA5);

        // Reset during bit 3 of 0x55 (start + 3 data bits + half a bit).
        while (div != 2) step();
        i_rx = 1'b0; repeat (64) step();
        i_rx = 1'b1; repeat (64) step();
        i_rx = 1'b0; repeat (64) step();
        i_rx = 1'b1; repeat (64) step();
        i_rx = 1'b0; repeat (32) step();
        rst  = 1'b1;
        i_rx = 1'b1;
        repeat (2) step();
        check("midrst_data", o_data, 8'h00);
        check("midrst_rda",  o_rda,  1'b0);
        rst = 1'b0;
        idle(70);
        send_frame(8'hA3, 1'b1, -1);
        check("after_rst_data", o_data, 8'hA3);
        check("after_rst_rda",  o_rda,  1'b1);
        bus_access(1'b0);

        // Glitch: 4 ticks low is rejected at mid start bit.
        while (div != 2) step();
        i_rx = 1'b0; repeat (16) step();
        idle(100);
        check("glitch_rda",  o_rda,  1'b0);
        check("glitch_ferr", o_ferr, 1'b0);
        check("glitch_data", o_data, 8'hA3);
        send_frame(8'h3C, 1'b1, -1);
        check("after_glitch_data", o_data, 8'h3C);
        check("after_glitch_rda",  o_rda,  1'b1);
        bus_access(1'b0);

        // Framing error: stop bit low.
        send_frame(8'h81, 1'b0, -1);
        idle(70);
        check("ferr_flag", o_ferr, 1'b1);
        check("ferr_rda",  o_rda,  1'b0);
        check("ferr_data", o_data, 8'h3C);
        bus_access(1'b0);
        check("ferr_cleared", o_ferr, 1'b0);

        // Overrun: two back-to-back frames, no read in between.
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        check("ovr_data", o_data, 8'h22);
        check("ovr_rda",  o_rda,  1'b1);
        check("ovr_flag", o_ovr,  1'b1);
        check("ovr_ferr", o_ferr, 1'b0);
        bus_access(1'b0);
        check("ovr_cleared", o_ovr, 1'b0);
        check("ovr_rda_cleared", o_rda, 1'b0);

        // Read on the exact completion cycle of the second byte.
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h7E, 1'b1, 610);
        check("coll_rda",  o_rda,  1'b1);
        check("coll_data", o_data, 8'h7E);
        check("coll_ovr",  o_ovr,  1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
